// File: rtl/rv32i_types.sv
// Shared types and constants for the cache-to-memory arbiter.
package rv32i_types;

    localparam int LINE_WIDTH = 256;
    localparam int BEAT_WIDTH = 64;
    localparam int BURST_LEN  = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_W      = $clog2(BURST_LEN);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_BURST,
        RESP
    } mem_arb_state_t;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } arb_client_t;

    // Memory is addressed by whole line: the byte offset is always dropped.
    function automatic logic [31:0] line_addr(input logic [31:0] a);
        return {a[31:5], 5'b0};
    endfunction

endpackage

// File: rtl/mem_arbiter_line_buf.sv
// Line register shared by read assembly and write serialisation, indexed by
// the arbiter's beat counter.
module mem_arb_line_buf
    import rv32i_types::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic [LINE_WIDTH-1:0] load_line,
    input  logic                  beat_we,
    input  logic [CNT_W-1:0]      cnt,
    input  logic [BEAT_WIDTH-1:0] beat_in,
    output logic [LINE_WIDTH-1:0] line_next,
    output logic [BEAT_WIDTH-1:0] beat_out
);

    logic [LINE_WIDTH-1:0] line_q;

    // Next line: whole-line load for writebacks, single-beat insert for reads.
    always_comb begin
        line_next = line_q;
        if (load_en) begin
            line_next = load_line;
        end else if (beat_we) begin
            line_next[BEAT_WIDTH*cnt +: BEAT_WIDTH] = beat_in;
        end
    end

    // Line storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
        end else begin
            line_q <= line_next;
        end
    end

    assign beat_out = line_q[BEAT_WIDTH*cnt +: BEAT_WIDTH];

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between icache and dcache line ports and a single
// 64-bit burst memory port. One line transaction in flight at a time.
module mem_arbiter
    import rv32i_types::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           i_addr,
    input  logic                  i_read,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic [31:0]           d_addr,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic [31:0]           bmem_addr,
    output logic                  bmem_read,
    output logic                  bmem_write,
    output logic [BEAT_WIDTH-1:0] bmem_wdata,
    input  logic                  bmem_ready,
    input  logic [31:0]           bmem_raddr,
    input  logic [BEAT_WIDTH-1:0] bmem_rdata,
    input  logic                  bmem_rvalid
);

    mem_arb_state_t        state_q, state_d;
    arb_client_t           client_q, client_d, rr_last_q, rr_last_d, grant;
    logic [31:0]           addr_q, addr_d;
    logic                  is_wr_q, is_wr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [LINE_WIDTH-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic                  i_pend, d_pend, load_en, beat_we;
    logic [LINE_WIDTH-1:0] line_next;
    logic [BEAT_WIDTH-1:0] beat_out;

    mem_arb_line_buf u_line_buf (
        .clk       (clk),
        .rst       (rst),
        .load_en   (load_en),
        .load_line (d_wdata),
        .beat_we   (beat_we),
        .cnt       (cnt_q),
        .beat_in   (bmem_rdata),
        .line_next (line_next),
        .beat_out  (beat_out)
    );

    // Next-state, grant and memory-port outputs.
    always_comb begin
        state_d    = state_q;
        client_d   = client_q;
        rr_last_d  = rr_last_q;
        addr_d     = addr_q;
        is_wr_d    = is_wr_q;
        cnt_d      = cnt_q;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        grant      = ICACHE;
        load_en    = 1'b0;
        beat_we    = 1'b0;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_addr  = '0;
        bmem_wdata = '0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        i_pend     = i_read;
        d_pend     = d_read | d_write;

        unique case (state_q)
            IDLE: begin
                if (i_pend || d_pend) begin
                    // rr_last only moves on contention; a lone requester is
                    // served without disturbing the fairness history.
                    if (i_pend && d_pend) begin
                        grant     = (rr_last_q == ICACHE) ? DCACHE : ICACHE;
                        rr_last_d = grant;
                    end else begin
                        grant = d_pend ? DCACHE : ICACHE;
                    end
                    client_d = grant;
                    addr_d   = line_addr((grant == DCACHE) ? d_addr : i_addr);
                    // A simultaneous read+write from dcache resolves to write.
                    is_wr_d  = (grant == DCACHE) && d_write;
                    load_en  = is_wr_d;
                    cnt_d    = '0;
                    state_d  = is_wr_d ? WR_BURST : RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                bmem_read = 1'b1;
                bmem_addr = addr_q;
                if (bmem_ready) begin
                    state_d = RD_WAIT;
                    cnt_d   = '0;
                end
            end
            RD_WAIT: begin
                // Only beats tagged with our line address belong to us.
                if (bmem_rvalid && (bmem_raddr == addr_q)) begin
                    beat_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = RESP;
                        if (client_q == ICACHE) i_rdata_d = line_next;
                        else                    d_rdata_d = line_next;
                    end
                end
            end
            WR_BURST: begin
                bmem_write = 1'b1;
                bmem_addr  = addr_q;
                bmem_wdata = beat_out;
                if (bmem_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) state_d = RESP;
                end
            end
            RESP: begin
                i_resp  = (client_q == ICACHE);
                d_resp  = (client_q == DCACHE);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and transaction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            client_q  <= ICACHE;
            rr_last_q <= ICACHE;
            addr_q    <= '0;
            is_wr_q   <= 1'b0;
            cnt_q     <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            client_q  <= client_d;
            rr_last_q <= rr_last_d;
            addr_q    <= addr_d;
            is_wr_q   <= is_wr_d;
            cnt_q     <= cnt_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

    // dcache must never ask for read and write in the same cycle.
    a_no_dcache_rw: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a behavioural memory answers read bursts,
// a monitor compares every memory-port beat and client response to queues of
// expectations pushed when the requests are driven.
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  i_addr, d_addr;
    logic         i_read, d_read, d_write;
    logic [255:0] i_rdata, d_rdata, d_wdata;
    logic         i_resp, d_resp;
    logic [31:0]  bmem_addr, bmem_raddr;
    logic         bmem_read, bmem_write, bmem_ready, bmem_rvalid;
    logic [63:0]  bmem_wdata, bmem_rdata;

    typedef struct { bit client; bit wr; logic [255:0] line; } exp_resp_t;
    typedef struct { logic [31:0] addr; logic [63:0] data; } exp_beat_t;

    exp_resp_t   resp_q[$];
    exp_beat_t   wbeat_q[$];
    logic [31:0] cmd_q[$];

    int n_chk = 0;
    int n_fail = 0;

    // memory model controls (written by the main sequence only)
    bit stray_en = 0;
    int idle_req = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
        .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory contents: a fixed byte pattern per beat, perturbed by address so
    // different lines differ. Line 0x1eceb000 holds the plain 11/22/33/44 beats.
    function automatic logic [63:0] mem_beat(input logic [31:0] a, input int k);
        logic [7:0] b;
        b = 8'(8'h11 * (k + 1));
        return {8{b}} ^ {32'h0, a ^ 32'h1eceb000};
    endfunction

    function automatic logic [255:0] line_for(input logic [31:0] a);
        logic [255:0] l;
        for (int k = 0; k < 4; k++) l[64*k +: 64] = mem_beat(a, k);
        return l;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom;
        return l;
    endfunction

    // Push expectations and raise the request.
    task automatic issue(input bit c, input bit wr, input logic [31:0] a, input logic [255:0] wd);
        exp_resp_t e;
        exp_beat_t b;
        logic [31:0] la;
        la = {a[31:5], 5'b0};
        e.client = c;
        e.wr = wr;
        e.line = wr ? '0 : line_for(la);
        resp_q.push_back(e);
        if (wr) begin
            for (int k = 0; k < 4; k++) begin
                b.addr = la;
                b.data = wd[64*k +: 64];
                wbeat_q.push_back(b);
            end
        end else begin
            cmd_q.push_back(la);
        end
        if (!c) begin
            i_addr = a;
            i_read = 1'b1;
        end else begin
            d_addr = a;
            d_wdata = wd;
            if (wr) d_write = 1'b1;
            else    d_read = 1'b1;
        end
    endtask

    // Drop each request in the cycle its response is seen.
    task automatic wait_resp(input int n);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (i_resp) begin i_read = 1'b0; got++; end
            if (d_resp) begin d_read = 1'b0; d_write = 1'b0; got++; end
        end
        if (got < n) chk("resp_timeout", 256'(got), 256'(n));
    endtask

    // Behavioural memory: after a read command is accepted, return four
    // tagged beats; optionally slip in a mis-tagged beat mid-burst, and
    // emit lone beats while idle on request.
    initial begin
        bit busy = 0, stray_done = 0;
        int k = 0, idle_ack = 0;
        logic [31:0] ra = '0;
        bmem_rvalid = 0; bmem_raddr = '0; bmem_rdata = '0;
        forever begin
            @(negedge clk);
            bmem_rvalid = 0;
            if (rst) begin
                busy = 0;
            end else begin
                if (busy) begin
                    if (stray_en && k == 2 && !stray_done) begin
                        bmem_rvalid = 1; bmem_raddr = 32'hdead0000; bmem_rdata = 64'hbad0bad0bad0bad0;
                        stray_done = 1;
                    end else begin
                        bmem_rvalid = 1; bmem_raddr = ra; bmem_rdata = mem_beat(ra, k);
                        k++;
                        if (k == 4) busy = 0;
                    end
                end else if (idle_ack != idle_req) begin
                    idle_ack = idle_req;
                    bmem_rvalid = 1; bmem_raddr = 32'h1eceb000; bmem_rdata = 64'hfeedfeedfeedfeed;
                end
                if (bmem_read && bmem_ready && !busy) begin
                    busy = 1; ra = bmem_addr; k = 0; stray_done = 0;
                end
            end
        end
    end

    // Monitor: compare memory-port activity and responses with the scoreboard.
    initial begin
        exp_resp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bmem_read || bmem_write) chk("rw_excl", 256'(bmem_read && bmem_write), 0);
                if (bmem_read) begin
                    if (cmd_q.size() == 0) chk("unexp_rd_cmd", 1, 0);
                    else begin
                        chk("rd_addr", bmem_addr, cmd_q[0]);
                        if (bmem_ready) void'(cmd_q.pop_front());
                    end
                end
                if (bmem_write) begin
                    if (wbeat_q.size() == 0) chk("unexp_wr_beat", 1, 0);
                    else begin
                        chk("wr_addr", bmem_addr, wbeat_q[0].addr);
                        chk("wr_data", bmem_wdata, wbeat_q[0].data);
                        if (bmem_ready) void'(wbeat_q.pop_front());
                    end
                end
                if (i_resp || d_resp) begin
                    chk("resp_both", 256'(i_resp && d_resp), 0);
                    if (resp_q.size() == 0) chk("unexp_resp", 1, 0);
                    else begin
                        e = resp_q.pop_front();
                        chk("resp_client", 256'(d_resp), 256'(e.client));
                        if (!e.wr) chk("rdata", e.client ? d_rdata : i_rdata, e.line);
                    end
                end
            end
        end
    end

    initial begin
        logic [255:0] wl, last_i;
        rst = 1; i_addr = 0; i_read = 0; d_addr = 0; d_read = 0; d_write = 0; d_wdata = 0;
        bmem_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_bmem_read", 256'(bmem_read), 0);
        chk("rst_bmem_write", 256'(bmem_write), 0);
        chk("rst_bmem_addr", bmem_addr, 0);
        chk("rst_bmem_wdata", bmem_wdata, 0);
        chk("rst_resp", 256'({i_resp, d_resp}), 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);

        // stray beat while idle, tagged with the address about to be read
        @(posedge clk); #1 idle_req++;
        repeat (3) @(posedge clk); #1;
        chk("idle_stray_i_rdata", i_rdata, 0);
        chk("idle_stray_resp", 256'({i_resp, d_resp}), 0);

        // icache read alone
        issue(0, 0, 32'h1eceb004, '0);
        wait_resp(1);
        chk("t1_line", i_rdata, {64'h4444444444444444, 64'h3333333333333333,
                                 64'h2222222222222222, 64'h1111111111111111});
        chk("t1_no_d_resp", 256'(d_resp), 0);

        // dcache writeback
        @(posedge clk); #1;
        wl = rand_line();
        issue(1, 1, 32'h1ecec020, wl);
        wait_resp(1);

        // simultaneous reads: dcache first after reset
        @(posedge clk); #1;
        issue(1, 0, 32'h20000080, '0);
        issue(0, 0, 32'h10000040, '0);
        wait_resp(2);
        // second pair: icache first; dcache writes this time
        @(posedge clk); #1;
        wl = rand_line();
        issue(0, 0, 32'h3000001c, '0);
        issue(1, 1, 32'h40000100, wl);
        wait_resp(2);
        chk("i_rdata_hold", i_rdata, line_for(32'h30000000));

        // backpressure on read issue
        @(posedge clk); #1;
        bmem_ready = 0;
        issue(0, 0, 32'h50000040, '0);
        repeat (6) @(posedge clk);
        #1 bmem_ready = 1;
        wait_resp(1);

        // backpressure between write beats 1 and 2
        @(posedge clk); #1;
        wl = rand_line();
        issue(1, 1, 32'h60000060, wl);
        repeat (3) @(posedge clk);
        #1 bmem_ready = 0;
        repeat (5) @(posedge clk);
        #1 bmem_ready = 1;
        wait_resp(1);

        // mis-tagged beat in the middle of a dcache read
        @(posedge clk); #1;
        stray_en = 1;
        issue(1, 0, 32'h70000020, '0);
        wait_resp(1);
        stray_en = 0;
        last_i = line_for(32'h50000040);
        chk("d_read_keeps_i_rdata", i_rdata, last_i);

        // reset after write beat 2 is accepted: only three beats go out
        @(posedge clk); #1;
        wl = rand_line();
        issue(1, 1, 32'h1ecec020, wl);
        void'(resp_q.pop_back());
        void'(wbeat_q.pop_back());
        repeat (4) @(posedge clk);
        #1 rst = 1; d_write = 0;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("rst_mid_write", 256'(bmem_write), 0);
        chk("rst_mid_addr", bmem_addr, 0);
        chk("rst_mid_beats_left", 256'(wbeat_q.size()), 0);
        repeat (6) @(negedge clk) chk("rst_mid_no_resp", 256'(d_resp), 0);

        // fresh icache read completes normally
        @(posedge clk); #1;
        issue(0, 0, 32'h1eceb000, '0);
        wait_resp(1);

        repeat (3) @(posedge clk);
        chk("sb_resp_drain", 256'(resp_q.size()), 0);
        chk("sb_cmd_drain", 256'(cmd_q.size()), 0);
        chk("sb_wbeat_drain", 256'(wbeat_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
